// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the configurable UART
// Purpose: FSM state enums, oversampling constants and the RX FIFO entry layout.
// Ports: none (package).
package uart_pkg;

    localparam int OS_RATE    = 16;  // ticks per bit period
    localparam int OS_MID     = 8;   // ticks from start edge to mid start bit
    localparam int MAX_DATA_W = 8;   // widest legal data field

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic                  par_err;
        logic                  frm_err;
    } rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead synchronous FIFO
// Purpose: single-clock FIFO; rd_data_o always presents the head entry.
// Ports: clk_i, rst_i (sync, active high), wr_en_i/wr_data_i push,
//        rd_en_i pop, rd_data_o head, full_o, empty_o.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign full_o    = (count == (AW+1)'(DEPTH));
    assign empty_o   = (count == '0);
    assign rd_ok     = rd_en_i && !empty_o;
    // A write into a full FIFO is accepted only when the head leaves in the same cycle.
    assign wr_ok     = wr_en_i && (!full_o || rd_ok);
    assign rd_data_o = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_cfg_top.sv
// rtl/uart_cfg_top.sv - runtime-configurable UART with TX and RX FIFOs
// Purpose: 16x oversampled UART; divisor, parity and stop bits set at run time.
// Ports: clk_i, rst_i (sync, active high); cfg_div_i/cfg_par_en_i/cfg_par_odd_i/
//        cfg_stop2_i config; tx_data_i/tx_data_vld_i/tx_full_o/tx_busy_o host TX;
//        rx_data_o/rx_par_err_o/rx_frm_err_o/rx_data_rd_en_i/rx_empty_o host RX;
//        rx_ovf_o/err_clr_i sticky overflow; uart_tx_o/uart_rx_i serial pins.
module uart_cfg_top #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic              cfg_par_en_i,
    input  logic              cfg_par_odd_i,
    input  logic              cfg_stop2_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_data_vld_i,
    output logic              tx_full_o,
    output logic              tx_busy_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_par_err_o,
    output logic              rx_frm_err_o,
    input  logic              rx_data_rd_en_i,
    output logic              rx_empty_o,
    output logic              rx_ovf_o,
    input  logic              err_clr_i,
    output logic              uart_tx_o,
    input  logic              uart_rx_i
);
    import uart_pkg::*;

    localparam logic [3:0] OS_LAST  = 4'(OS_RATE - 1);
    localparam logic [3:0] MID_LAST = 4'(OS_MID - 1);
    localparam logic [3:0] BIT_LAST = 4'(DATA_W - 1);

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;

    // >= keeps the counter bounded if the divisor is lowered while running.
    assign tick = (tick_cnt >= cfg_div_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ---------------- TX path ----------------
    tx_state_t         tx_state;
    logic [3:0]        tx_os;
    logic [3:0]        tx_bit;
    logic [DATA_W-1:0] tx_shr;
    logic              tx_par_en;
    logic              tx_stop2;
    logic              tx_par;
    logic [DATA_W-1:0] tx_fifo_dout;
    logic              tx_fifo_empty;
    logic              tx_bit_end;
    logic              tx_stop_done;
    logic              tx_load;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (tx_data_vld_i),
        .wr_data_i (tx_data_i),
        .rd_en_i   (tx_load),
        .rd_data_o (tx_fifo_dout),
        .full_o    (tx_full_o),
        .empty_o   (tx_fifo_empty)
    );

    assign tx_bit_end   = tick && (tx_os == OS_LAST);
    assign tx_stop_done = (tx_state == TX_STOP) && tx_bit_end &&
                          (tx_bit == (tx_stop2 ? 4'd1 : 4'd0));
    // Loading straight out of the last stop bit gives back-to-back frames.
    assign tx_load      = tick && !tx_fifo_empty &&
                          ((tx_state == TX_IDLE) || tx_stop_done);
    assign tx_busy_o    = !tx_fifo_empty || (tx_state != TX_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state  <= TX_IDLE;
            tx_os     <= '0;
            tx_bit    <= '0;
            tx_shr    <= '0;
            tx_par_en <= 1'b0;
            tx_stop2  <= 1'b0;
            tx_par    <= 1'b0;
        end else if (tx_load) begin
            tx_state  <= TX_START;
            tx_os     <= '0;
            tx_bit    <= '0;
            tx_shr    <= tx_fifo_dout;
            tx_par_en <= cfg_par_en_i;
            tx_stop2  <= cfg_stop2_i;
            tx_par    <= (^tx_fifo_dout) ^ cfg_par_odd_i;
        end else if (tick && (tx_state != TX_IDLE)) begin
            tx_os <= tx_os + 1'b1;
            if (tx_os == OS_LAST) begin
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                    end
                    TX_DATA: begin
                        tx_shr <= tx_shr >> 1;
                        if (tx_bit == BIT_LAST) begin
                            tx_bit   <= '0;
                            tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        tx_bit   <= '0;
                    end
                    TX_STOP: begin
                        if (tx_stop_done) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        uart_tx_o = 1'b1;
        case (tx_state)
            TX_START:  uart_tx_o = 1'b0;
            TX_DATA:   uart_tx_o = tx_shr[0];
            TX_PARITY: uart_tx_o = tx_par;
            default:   uart_tx_o = 1'b1;
        endcase
    end

    // ---------------- RX path ----------------
    rx_state_t         rx_state;
    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic [3:0]        rx_os;
    logic [3:0]        rx_bit;
    logic [DATA_W-1:0] rx_shr;
    logic              rx_par_en;
    logic              rx_odd;
    logic              rx_stop2;
    logic              rx_par_err;
    logic              rx_frm_err;
    logic              rx_push;
    logic              rx_full;
    logic [DATA_W+1:0] rx_fifo_dout;
    rx_entry_t         rx_head;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state   <= RX_IDLE;
            rx_os      <= '0;
            rx_bit     <= '0;
            rx_shr     <= '0;
            rx_par_en  <= 1'b0;
            rx_odd     <= 1'b0;
            rx_stop2   <= 1'b0;
            rx_par_err <= 1'b0;
            rx_frm_err <= 1'b0;
            rx_push    <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            if (rx_state == RX_IDLE) begin
                if (rx_prev && !rx_sync) begin
                    rx_state   <= RX_START;
                    rx_os      <= '0;
                    rx_par_en  <= cfg_par_en_i;
                    rx_odd     <= cfg_par_odd_i;
                    rx_stop2   <= cfg_stop2_i;
                    rx_par_err <= 1'b0;
                end
            end else if (tick) begin
                rx_os <= rx_os + 1'b1;
                case (rx_state)
                    RX_START: begin
                        if (rx_os == MID_LAST) begin
                            rx_os  <= '0;
                            rx_bit <= '0;
                            // Line back high at mid start bit: a glitch, not a frame.
                            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (rx_os == OS_LAST) begin
                            rx_shr <= {rx_sync, rx_shr[DATA_W-1:1]};
                            if (rx_bit == BIT_LAST) begin
                                rx_bit   <= '0;
                                rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit <= rx_bit + 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (rx_os == OS_LAST) begin
                            rx_par_err <= rx_sync != ((^rx_shr) ^ rx_odd);
                            rx_state   <= RX_STOP;
                            rx_bit     <= '0;
                        end
                    end
                    RX_STOP: begin
                        if (rx_os == OS_LAST) begin
                            if (rx_bit == 4'd0) begin
                                rx_frm_err <= !rx_sync;
                                rx_push    <= 1'b1;
                                if (rx_stop2) begin
                                    rx_bit <= 4'd1;
                                end else begin
                                    rx_state <= RX_IDLE;
                                end
                            end else begin
                                rx_state <= RX_IDLE;
                            end
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (rx_push),
        .wr_data_i ({rx_shr, rx_par_err, rx_frm_err}),
        .rd_en_i   (rx_data_rd_en_i),
        .rd_data_o (rx_fifo_dout),
        .full_o    (rx_full),
        .empty_o   (rx_empty_o)
    );

    // Head is forced to zero while empty so stale memory never shows.
    assign rx_head = rx_empty_o ? '0 :
                     '{data:    MAX_DATA_W'(rx_fifo_dout[DATA_W+1:2]),
                       par_err: rx_fifo_dout[1],
                       frm_err: rx_fifo_dout[0]};

    assign rx_data_o    = rx_head.data[DATA_W-1:0];
    assign rx_par_err_o = rx_head.par_err;
    assign rx_frm_err_o = rx_head.frm_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_ovf_o <= 1'b0;
        end else if (rx_push && rx_full && !rx_data_rd_en_i) begin
            rx_ovf_o <= 1'b1;
        end else if (err_clr_i) begin
            rx_ovf_o <= 1'b0;
        end
    end

endmodule
